pipelined_carry_select_subtractor: RTL and testbench

//  Pipelined WIDTH-bit subtractor: diff = a - b - bin, with borrow-out and signed overflow.

---
 rtl/pipelined_carry_select_subtractor.sv | 228 ++++++++++++++++++++++
 tb/tb_pipelined_carry_select_subtractor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_select_subtractor.sv
// ---------------------------------------------------------------------------
// pipelined_carry_select_subtractor
//
// Purpose:
//   Pipelined WIDTH-bit subtractor computing diff = a - b - bin together with
//   the unsigned borrow-out and the two's-complement signed overflow flag.
//   The operand is split into SLICE-bit slices. Each pipeline stage resolves
//   exactly one slice using a carry-select scheme:
//    - two ripple differences are formed in parallel, one assuming borrow-in 0
//      and one assuming borrow-in 1;
//    - the registered borrow from the previous stage (or bin for stage 0)
//      picks the correct one.
//   Throughput is one result per cycle. Latency is STAGES = WIDTH/SLICE
//   cycles when the pipe is not stalled.
//
// Flow control:
//   One global advance enable, en = !out_valid | out_ready, moves every stage
//   at once. in_ready is en, so the producer sees back-pressure in the same
//   cycle the consumer stalls. Bubbles travel with the pipe; they are not
//   collapsed while it is stalled.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      input operands valid
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in, subtracted at bit 0
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result this cycle
//   diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//   bout       out  1      borrow-out, 1 iff a < b + bin (unsigned)
//   ovf        out  1      signed overflow of a - b - bin
// ---------------------------------------------------------------------------
module pipelined_carry_select_subtractor #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   // One pipeline stage per slice. This value is derived from the
   // parameters and is not meant to be overridden.
   localparam int STAGES = WIDTH / SLICE;

   logic en;
   logic ovf_q;
   logic ovf_d;

   // Ripple subtractor for one slice.
   // Returns {borrowOut, difference}.
   // The borrow out of a bit position is set in two cases:
   //  - the subtrahend bit is 1 and the minuend bit is 0;
   //  - the two bits are equal and a borrow is already coming in.
   function automatic logic [SLICE:0] rippleSub(
      input logic [SLICE-1:0] x,
      input logic [SLICE-1:0] y,
      input logic             borrowIn
   );
      logic [SLICE-1:0] d;
      logic             br;
      br = borrowIn;
      d  = '0;
      for (int i = 0; i < SLICE; i++) begin
         d[i] = x[i] ^ y[i] ^ br;
         br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
      end
      return {br, d};
   endfunction

   // Every stage advances together. While the output register holds a
   // result that the consumer has not taken, the whole pipe freezes and no
   // new operands are accepted.
   assign en       = !out_valid | out_ready;
   assign in_ready = en;

   // Build one stage per slice. Stage k registers:
   //  - the k+1 low slices of the difference resolved so far;
   //  - the borrow out of slice k;
   //  - the valid bit for this stage.
   // All stages except the last also carry:
   //  - the still-unresolved upper slices of a and b;
   //  - the operand sign bits, which the last stage needs for overflow.
   for (genvar k = 0; k < STAGES; k++) begin : gStage

      localparam int RES = (k + 1) * SLICE;
      localparam int REM = WIDTH - RES;

      logic [SLICE-1:0] sliceA;
      logic [SLICE-1:0] sliceB;
      logic             borrowIn;
      logic             validIn;
      logic             aMsbIn;
      logic             bMsbIn;
      logic [SLICE:0]   subZero;
      logic [SLICE:0]   subOne;
      logic [SLICE:0]   subSel;

      logic             valid_q;
      logic             valid_d;
      logic             borrow_q;
      logic             borrow_d;
      logic [RES-1:0]   diff_q;
      logic [RES-1:0]   diff_d;

      // Carry-select core.
      // Both borrow-in hypotheses are evaluated in parallel. Only the
      // borrow coming from the previous stage decides which one is kept,
      // so the critical path is one SLICE-wide ripple plus a mux.
      assign subZero  = rippleSub(sliceA, sliceB, 1'b0);
      assign subOne   = rippleSub(sliceA, sliceB, 1'b1);
      assign subSel   = borrowIn ? subOne : subZero;

      assign valid_d  = en ? validIn : valid_q;
      assign borrow_d = en ? subSel[SLICE] : borrow_q;

      if (k == 0) begin : gFirst
         // The first stage takes its slice straight from the ports.
         assign sliceA   = a[SLICE-1:0];
         assign sliceB   = b[SLICE-1:0];
         assign borrowIn = bin;
         assign validIn  = in_valid;
         assign aMsbIn   = a[WIDTH-1];
         assign bMsbIn   = b[WIDTH-1];
         assign diff_d   = en ? subSel[SLICE-1:0] : diff_q;
      end else begin : gNext
         // Later stages consume the lowest unresolved slice from their
         // predecessor. The new slice is appended above the bits that
         // are already resolved.
         assign sliceA   = gStage[k-1].gCarry.aRem_q[SLICE-1:0];
         assign sliceB   = gStage[k-1].gCarry.bRem_q[SLICE-1:0];
         assign borrowIn = gStage[k-1].borrow_q;
         assign validIn  = gStage[k-1].valid_q;
         assign aMsbIn   = gStage[k-1].gCarry.aMsb_q;
         assign bMsbIn   = gStage[k-1].gCarry.bMsb_q;
         assign diff_d   = en ? {subSel[SLICE-1:0], gStage[k-1].diff_q} : diff_q;
      end

      if (k < STAGES - 1) begin : gCarry
         logic [REM-1:0] aRem_q;
         logic [REM-1:0] aRem_d;
         logic [REM-1:0] bRem_q;
         logic [REM-1:0] bRem_d;
         logic           aMsb_q;
         logic           aMsb_d;
         logic           bMsb_q;
         logic           bMsb_d;

         if (k == 0) begin : gLoad
            assign aRem_d = en ? a[WIDTH-1:SLICE] : aRem_q;
            assign bRem_d = en ? b[WIDTH-1:SLICE] : bRem_q;
         end else begin : gShift
            // Drop the slice just resolved; the remainder shrinks by
            // one slice per stage.
            assign aRem_d = en ? gStage[k-1].gCarry.aRem_q[REM+SLICE-1:SLICE] : aRem_q;
            assign bRem_d = en ? gStage[k-1].gCarry.bRem_q[REM+SLICE-1:SLICE] : bRem_q;
         end

         assign aMsb_d = en ? aMsbIn : aMsb_q;
         assign bMsb_d = en ? bMsbIn : bMsb_q;

         // Operand bookkeeping registers for the slices still to come.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               aRem_q <= '0;
               bRem_q <= '0;
               aMsb_q <= 1'b0;
               bMsb_q <= 1'b0;
            end else begin
               aRem_q <= aRem_d;
               bRem_q <= bRem_d;
               aMsb_q <= aMsb_d;
               bMsb_q <= bMsb_d;
            end
         end
      end else begin : gLast
         // Overflow is judged on the final difference, so bin is already
         // included. Subtracting operands of opposite sign overflows when
         // the result's sign differs from the minuend's sign.
         // subSel[SLICE-1] is the top bit of the top slice, i.e. diff[MSB].
         assign ovf_d = en ? ((aMsbIn ^ bMsbIn) & (subSel[SLICE-1] ^ aMsbIn)) : ovf_q;
      end

      // Per-stage valid, borrow and resolved-difference registers. The
      // async reset drops every in-flight operand immediately.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            valid_q  <= 1'b0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
         end else begin
            valid_q  <= valid_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
         end
      end
   end

   // The overflow flag exists only at the output stage. Its register lives
   // here so the output port has a single obvious source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   // The last stage is the output register. It holds its contents while
   // stalled and while idle, which keeps diff/bout/ovf stable.
   assign out_valid = gStage[STAGES-1].valid_q;
   assign diff      = gStage[STAGES-1].diff_q;
   assign bout      = gStage[STAGES-1].borrow_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_carry_select_subtractor.sv
// ---------------------------------------------------------------------------
// tb_pipelined_carry_select_subtractor
//
// Self-checking bench for the 16-bit / 4-bit-slice pipelined subtractor.
//  - The driver pushes a hand-computed expected result into a queue for
//    every operand set the DUT accepts.
//  - The monitor compares every presented output against the queue head.
//    It pops only on an actual transfer, so stalled outputs are checked
//    for stability against the same expected value.
// ---------------------------------------------------------------------------
module tb_pipelined_carry_select_subtractor;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        bout;
   logic        ovf;

   typedef struct packed {
      logic [15:0] d;
      logic        bo;
      logic        ov;
   } exp_t;

   typedef struct packed {
      logic [15:0] av;
      logic [15:0] bv;
      logic        bi;
      logic [15:0] ed;
      logic        eb;
      logic        eo;
   } vec_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;
   int   latency;

   pipelined_carry_select_subtractor #(.WIDTH(16), .SLICE(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Single comparison point; every check goes through here.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Present one operand set on a falling edge and hold it until the DUT
   // accepts it. The expectation is queued at the moment of acceptance.
   task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                input logic bi, input logic [15:0] ed,
                                input logic eb, input logic eo);
      int waitCnt;
      waitCnt = 0;
      @(negedge clk);
      a        = av;
      b        = bv;
      bin      = bi;
      in_valid = 1'b1;
      while (!in_ready && waitCnt < 200) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!in_ready) begin
         checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
         in_valid = 1'b0;
      end else begin
         expQ.push_back('{d: ed, bo: eb, ov: eo});
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic applyVec(input vec_t v);
      applyStimulus(v.av, v.bv, v.bi, v.ed, v.eb, v.eo);
   endtask

   // Wait, with a bound, until every queued expectation has been consumed.
   task automatic waitDrain(input string name);
      int c;
      c = 0;
      while (expQ.size() != 0 && c < 100) begin
         @(negedge clk);
         c++;
      end
      #1;
      checkOutput(name, expQ.size(), 32'd0);
   endtask

   // Monitor: compare every presented result with the scoreboard head. It
   // pops on a transfer only, and checks back-pressure while stalled.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_result", {31'd0, out_valid}, 32'd0);
         end else begin
            checkOutput("result", {14'd0, diff, bout, ovf}, {14'd0, expQ[0]});
            if (!out_ready) begin
               checkOutput("in_ready_stall", {31'd0, in_ready}, 32'd0);
            end else begin
               void'(expQ.pop_front());
            end
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t t4 [8];
      vec_t t5 [4];
      vec_t t6 [3];

      t4[0] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      t4[1] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
      t4[2] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
      t4[3] = '{16'h7000, 16'h9000, 1'b0, 16'hE000, 1'b1, 1'b1};
      t4[4] = '{16'h0100, 16'h00FF, 1'b1, 16'h0000, 1'b0, 1'b0};
      t4[5] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
      t4[6] = '{16'h1234, 16'h5678, 1'b1, 16'hBBBB, 1'b1, 1'b0};
      t4[7] = '{16'hF00F, 16'h0FF0, 1'b0, 16'hE01F, 1'b0, 1'b0};

      t5[0] = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0};
      t5[1] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      t5[2] = '{16'h4000, 16'hC000, 1'b0, 16'h8000, 1'b1, 1'b1};
      t5[3] = '{16'h00FF, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b0};

      t6[0] = '{16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 1'b0};
      t6[1] = '{16'h0003, 16'h0004, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      t6[2] = '{16'hC000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b0};

      // Reset state.
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      #1 rst = 1'b1;
      #2;
      checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_diff", {16'd0, diff}, 32'd0);
      checkOutput("reset_bout_ovf", {30'd0, bout, ovf}, 32'd0);
      checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      // Basic subtraction and first-result latency.
      applyStimulus(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
      latency = 0;
      do begin
         @(negedge clk);
         latency++;
      end while (!out_valid && latency < 20);
      checkOutput("latency", latency, 32'd4);
      waitDrain("drain_basic");

      // Borrow rippling across every slice boundary.
      applyStimulus(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      applyStimulus(16'h1000, 16'h0000, 1'b1, 16'h0FFF, 1'b0, 1'b0);
      waitDrain("drain_ripple");

      // Signed overflow in both directions.
      applyStimulus(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      applyStimulus(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
      waitDrain("drain_ovf");

      // Back-to-back issue with the consumer toggling ready.
      fork
         begin
            for (int i = 0; i < 8; i++) applyVec(t4[i]);
         end
         begin
            repeat (16) begin
               @(posedge clk);
               #2 out_ready = ~out_ready;
            end
         end
      join
      @(posedge clk);
      #2 out_ready = 1'b1;
      waitDrain("drain_toggle");

      // Fill the pipe against a stalled consumer, hold, then release.
      @(posedge clk);
      #2 out_ready = 1'b0;
      for (int i = 0; i < 4; i++) applyVec(t5[i]);
      repeat (10) begin
         @(negedge clk);
         checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
      end
      checkOutput("stall_queue_depth", expQ.size(), 32'd4);
      @(posedge clk);
      #2 out_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      checkOutput("drain_rate", expQ.size(), 32'd0);
      @(negedge clk);
      checkOutput("drain_idle", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset with three operands in flight.
      for (int i = 0; i < 3; i++) applyVec(t6[i]);
      #2;
      expQ.delete();
      rst = 1'b1;
      #1;
      checkOutput("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("async_rst_diff", {16'd0, diff}, 32'd0);
      checkOutput("async_rst_bout_ovf", {30'd0, bout, ovf}, 32'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         checkOutput("post_rst_idle", {31'd0, out_valid}, 32'd0);
      end
      applyStimulus(16'h2222, 16'h1111, 1'b0, 16'h1111, 1'b0, 1'b0);
      waitDrain("drain_post_rst");

      repeat (3) @(negedge clk);
      checkOutput("final_queue_empty", expQ.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
